// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller running on the system clock; TCK edges are detected from the
// synchronized TCK level and drive the 16-state FSM, the instruction register and TDO.
module jtag_tap_ctrl #(
    parameter int unsigned IR_WIDTH = 4,
    parameter logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(4'b0001)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tck_sync,
    input  logic                tms_sync,
    input  logic                tdi_sync,
    input  logic                dr_tdo,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic                tlr,
    output logic                tdo,
    output logic                tdo_en
);

    typedef enum logic [3:0] {
        StTlr   = 4'd0,
        StRti   = 4'd1,
        StSelDr = 4'd2,
        StCapDr = 4'd3,
        StShDr  = 4'd4,
        StEx1Dr = 4'd5,
        StPaDr  = 4'd6,
        StEx2Dr = 4'd7,
        StUpdDr = 4'd8,
        StSelIr = 4'd9,
        StCapIr = 4'd10,
        StShIr  = 4'd11,
        StEx1Ir = 4'd12,
        StPaIr  = 4'd13,
        StEx2Ir = 4'd14,
        StUpdIr = 4'd15
    } tap_state_e;

    tap_state_e          state;
    tap_state_e          next_state;
    logic                tck_prev;
    logic [IR_WIDTH-1:0] ir_shift;
    logic                tck_rise;
    logic                tck_fall;

    assign tck_rise = tck_sync & ~tck_prev;
    assign tck_fall = ~tck_sync & tck_prev;

    always_comb begin
        next_state = state;
        unique case (state)
            StTlr:   next_state = tms_sync ? StTlr   : StRti;
            StRti:   next_state = tms_sync ? StSelDr : StRti;
            StSelDr: next_state = tms_sync ? StSelIr : StCapDr;
            StCapDr: next_state = tms_sync ? StEx1Dr : StShDr;
            StShDr:  next_state = tms_sync ? StEx1Dr : StShDr;
            StEx1Dr: next_state = tms_sync ? StUpdDr : StPaDr;
            StPaDr:  next_state = tms_sync ? StEx2Dr : StPaDr;
            StEx2Dr: next_state = tms_sync ? StUpdDr : StShDr;
            StUpdDr: next_state = tms_sync ? StSelDr : StRti;
            StSelIr: next_state = tms_sync ? StTlr   : StCapIr;
            StCapIr: next_state = tms_sync ? StEx1Ir : StShIr;
            StShIr:  next_state = tms_sync ? StEx1Ir : StShIr;
            StEx1Ir: next_state = tms_sync ? StUpdIr : StPaIr;
            StPaIr:  next_state = tms_sync ? StEx2Ir : StPaIr;
            StEx2Ir: next_state = tms_sync ? StUpdIr : StShIr;
            StUpdIr: next_state = tms_sync ? StSelDr : StRti;
            default: next_state = StTlr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StTlr;
            tck_prev <= 1'b0;
            ir       <= IR_RESET;
            ir_shift <= '0;
            tdo      <= 1'b0;
            tdo_en   <= 1'b0;
        end else begin
            tck_prev <= tck_sync;
            if (tck_rise) begin
                // Rising-edge IR actions are keyed on the state being left.
                if (state == StCapIr) begin
                    ir_shift <= IR_WIDTH'(2'b01);
                end else if (state == StShIr) begin
                    ir_shift <= {tdi_sync, ir_shift[IR_WIDTH-1:1]};
                end
                state <= next_state;
            end
            if (tck_fall) begin
                if (state == StUpdIr) begin
                    ir <= ir_shift;
                end else if (state == StTlr) begin
                    ir <= IR_RESET;
                end
                tdo    <= (state == StShIr) ? ir_shift[0] : dr_tdo;
                tdo_en <= (state == StShIr) || (state == StShDr);
            end
        end
    end

    // Strobes last exactly the one clk in which the edge is visible.
    assign capture_dr = tck_rise && (state == StCapDr);
    assign shift_dr   = tck_rise && (state == StShDr);
    assign update_dr  = tck_fall && (state == StUpdDr);
    assign tlr        = (state == StTlr);
    assign tap_state  = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed TAP walks plus random TMS/TDI traffic,
// compared against a TCK-level behavioural model of the 1149.1 state machine.
module tb_jtag_tap_ctrl;

    logic       clk = 1'b0;
    logic       rst, tck, tms, tdi, dr_tdo;
    logic [3:0] tap_state, ir;
    logic       capture_dr, shift_dr, update_dr, tlr, tdo, tdo_en;

    jtag_tap_ctrl #(.IR_WIDTH(4), .IR_RESET(4'b0001)) dut (
        .clk        (clk),
        .rst        (rst),
        .tck_sync   (tck),
        .tms_sync   (tms),
        .tdi_sync   (tdi),
        .dr_tdo     (dr_tdo),
        .tap_state  (tap_state),
        .ir         (ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .tlr        (tlr),
        .tdo        (tdo),
        .tdo_en     (tdo_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int nxt0[16];
    int nxt1[16];
    int mstate, mir, mshift, mtdo, mtdo_en;
    int exp_cap = 0, exp_sh = 0, exp_upd = 0;
    int cap_cnt = 0, sh_cnt = 0, upd_cnt = 0, overlap_cnt = 0;
    int c0, s0, u0;

    // Strobe widths are measured in clks, so counts equal pulses only if each is one clk wide.
    always @(negedge clk) begin
        if (!rst) begin
            cap_cnt += int'(capture_dr);
            sh_cnt  += int'(shift_dr);
            upd_cnt += int'(update_dr);
            if (int'(capture_dr) + int'(shift_dr) + int'(update_dr) > 1) overlap_cnt++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"}, int'(tap_state), mstate);
        check({tag, ".ir"}, int'(ir), mir);
        check({tag, ".tdo"}, int'(tdo), mtdo);
        check({tag, ".tdo_en"}, int'(tdo_en), mtdo_en);
        check({tag, ".tlr"}, int'(tlr), int'(mstate == 0));
    endtask

    task automatic check_strobes(input string tag);
        check({tag, ".cap_cnt"}, cap_cnt, exp_cap);
        check({tag, ".sh_cnt"}, sh_cnt, exp_sh);
        check({tag, ".upd_cnt"}, upd_cnt, exp_upd);
        check({tag, ".overlap"}, overlap_cnt, 0);
    endtask

    function automatic void model_reset();
        mstate = 0; mir = 1; mshift = 0; mtdo = 0; mtdo_en = 0;
    endfunction

    function automatic void model_rise(input bit tms_v, input bit tdi_v);
        if (mstate == 3) exp_cap++;
        if (mstate == 4) exp_sh++;
        if (mstate == 10) mshift = 1;
        if (mstate == 11) mshift = (mshift >> 1) | (int'(tdi_v) << 3);
        mstate = tms_v ? nxt1[mstate] : nxt0[mstate];
    endfunction

    function automatic void model_fall(input bit dro);
        if (mstate == 8) exp_upd++;
        if (mstate == 15) mir = mshift;
        else if (mstate == 0) mir = 1;
        mtdo    = (mstate == 11) ? (mshift & 1) : int'(dro);
        mtdo_en = int'(mstate == 11 || mstate == 4);
    endfunction

    // Drive one TCK level, hold it n clks, then compare at a falling clk edge.
    task automatic half(input bit lvl, input bit tms_v, input bit tdi_v, input bit dro,
                        input int n);
        @(posedge clk);
        #1;
        tck = lvl; tms = tms_v; tdi = tdi_v; dr_tdo = dro;
        if (lvl) model_rise(tms_v, tdi_v);
        else model_fall(dro);
        repeat (n) @(posedge clk);
        @(negedge clk);
        check_all(lvl ? "rise" : "fall");
    endtask

    task automatic pulse(input bit tms_v, input bit tdi_v);
        bit dro;
        dro = 1'($urandom);
        half(1'b1, tms_v, tdi_v, dro, int'($urandom_range(1, 3)));
        half(1'b0, tms_v, tdi_v, dro, int'($urandom_range(1, 3)));
    endtask

    initial begin
        // Transition table: index = state, value = successor for tms=0 / tms=1.
        nxt0 = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
        nxt1 = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
        rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; dr_tdo = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        check("tlr_hold.ir", int'(ir), 1);

        // Enter SH_IR and shift 1,0,1,0 LSB first, then update.
        pulse(1'b0, 1'b0); pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b0);
        check("sh_ir.state", int'(tap_state), 11);
        check("sh_ir.tdo0", int'(tdo), 1);
        pulse(1'b0, 1'b1); pulse(1'b0, 1'b0); pulse(1'b0, 1'b1); pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check("ir_update", int'(ir), 5);
        pulse(1'b0, 1'b0);

        // RTI -> capture and three DR shifts.
        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        pulse(1'b1, 1'b0); pulse(1'b0, 1'b0); pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b1); pulse(1'b0, 1'b0); pulse(1'b1, 1'b1);
        check("dr.cap_pulses", cap_cnt - c0, 1);
        check("dr.shift_pulses", sh_cnt - s0, 3);

        // EX1_DR -> PA_DR held 4 TCKs -> EX2_DR -> SH_DR and resume.
        s0 = sh_cnt;
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b0);
        check("pause.no_shift", sh_cnt - s0, 0);
        pulse(1'b1, 1'b0); pulse(1'b0, 1'b0);
        check("pause.back_sh_dr", int'(tap_state), 4);
        pulse(1'b0, 1'b1); pulse(1'b1, 1'b0);
        check("pause.resume", sh_cnt - s0, 2);
        pulse(1'b1, 1'b0); pulse(1'b0, 1'b0);
        check("dr.update_pulses", upd_cnt - u0, 1);
        check_strobes("directed");

        // TCK stuck high in SH_IR for 20 clks.
        pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); pulse(1'b0, 1'b0);
        s0 = sh_cnt; c0 = cap_cnt;
        half(1'b1, 1'b0, 1'b1, 1'b0, 20);
        check("stuck.state", int'(tap_state), 11);
        check("stuck.strobes", (sh_cnt - s0) + (cap_cnt - c0), 0);
        half(1'b0, 1'b0, 1'b1, 1'b0, 1);
        pulse(1'b0, 1'b1);

        // Asynchronous reset in the middle of an IR shift.
        @(posedge clk);
        #3 rst = 1'b1; tck = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Random traffic with TMS biased towards staying put.
        for (int i = 0; i < 150; i++) pulse(1'($urandom_range(0, 2) == 0), 1'($urandom));
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'($urandom));
        check("five_tms.state", int'(tap_state), 0);
        check_strobes("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
IEEE 1149.1 TAP controller clocked entirely by the system clock. Consumes the synchronized TCK/TMS/TDI bits produced by the input synchronizer stage directly upstream. Detects TCK edges, runs the 16-state TAP FSM and owns the instruction register. Emits one-clk DR strobes and a registered TDO/TDO-enable for the downstream data registers and pad.

Parameters:
IR_WIDTH, 4, instruction register width; must be >= 2
IR_RESET, 4'b0001, IR value loaded on reset and while in Test-Logic-Reset (IDCODE)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
tck_sync  input  1  synchronized TCK level
tms_sync  input  1  synchronized TMS
tdi_sync  input  1  synchronized TDI
dr_tdo  input  1  serial output of the currently selected DR
tap_state  output  4  current FSM state (encoding below)
ir  output  IR_WIDTH  active instruction
capture_dr  output  1  one-clk strobe: capture selected DR
shift_dr  output  1  one-clk strobe: shift selected DR one bit (tdi_sync valid)
update_dr  output  1  one-clk strobe: update selected DR
tlr  output  1  high while state == TEST_LOGIC_RESET
tdo  output  1  registered serial out
tdo_en  output  1  TDO output enable

Behaviour:
- Reset (rst=1, async): tap_state=TLR(0); ir=IR_RESET; ir_shift=0; tck_prev=0; tdo=0; tdo_en=0; all strobes 0; tlr=1.
- Edge detect: tck_prev <= tck_sync every clk. tck_rise = tck_sync & ~tck_prev. tck_fall = ~tck_sync & tck_prev. Both are combinational and mutually exclusive.
- Encoding: TLR=0, RTI=1, SEL_DR=2, CAP_DR=3, SH_DR=4, EX1_DR=5, PA_DR=6, EX2_DR=7, UPD_DR=8, SEL_IR=9, CAP_IR=10, SH_IR=11, EX1_IR=12, PA_IR=13, EX2_IR=14, UPD_IR=15.
- FSM advances only on clk cycles with tck_rise; otherwise it holds. Transitions are listed as tms=0 target / tms=1 target:
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - SEL_IR: CAP_IR / TLR
  - CAP_x: SH_x / EX1_x
  - SH_x: SH_x / EX1_x
  - EX1_x: PA_x / UPD_x
  - PA_x: PA_x / EX2_x
  - EX2_x: SH_x / UPD_x
  - UPD_x: RTI / SEL_DR
- Rising-edge actions, based on the state before the transition:
  - CAP_IR: ir_shift <= {0..., 2'b01}.
  - SH_IR: ir_shift <= {tdi_sync, ir_shift[IR_WIDTH-1:1]} (LSB first).
  - CAP_DR: capture_dr=1 for that clk.
  - SH_DR: shift_dr=1 for that clk.
- Falling-edge actions, based on the current state:
  - UPD_IR: ir <= ir_shift.
  - UPD_DR: update_dr=1 for that clk.
  - TLR: ir <= IR_RESET.
  - tdo <= (SH_IR ? ir_shift[0] : dr_tdo).
  - tdo_en <= (state==SH_IR || state==SH_DR).
  - tdo/tdo_en change only on tck_fall.
- Strobes are combinational from state and edge, exactly one clk wide per TCK edge, and never overlap.
- Five consecutive tck_rise with tms_sync=1 reach TLR from any state.
- tck_sync held constant: no state change, no strobes.
- rst mid-shift: immediate return to TLR; ir_shift contents discarded; ir=IR_RESET.
- tck_prev resets to 0, so tck_sync=1 in the first clk after reset counts as a rise. This is expected; the upstream synchronizer also resets to 0.

Test Plan:
- Reset, then 5 TCK pulses with TMS=1 -> tap_state=0, tlr=1, ir=4'b0001, tdo_en=0 throughout.
- From TLR, TMS sequence 0,1,1,0,0 -> tap_state=11 (SH_IR); shift TDI bits 1,0,1,0 (last bit with TMS=1), then TMS 1,0 -> ir=4'b0101 after UPD_IR falling edge. TDO over the four shift cycles reads 1,0,0,0 (captured 0001 pattern, LSB first).
- From RTI, TMS 1,0,0 then 3 shift cycles -> capture_dr exactly 1 pulse, shift_dr exactly 3 pulses (3 clk total), tdo mirrors dr_tdo on each fall, tdo_en=1 only during SH_DR.
- Pause path: SH_DR -> EX1_DR -> PA_DR (hold 4 TCK) -> EX2_DR -> SH_DR -> no shift_dr pulses while paused, shift resumes.
- TCK held high 20 clks in SH_IR -> no state change, ir_shift stable.
- Assert rst mid SH_IR after 2 bits -> tap_state=0, ir=4'b0001, tdo=0, tdo_en=0 in the same cycle (async).
